// File: rtl/cache_pkg.sv
// Shared cache types: the block container, the backing-memory responder
// state set and the block-index helper. Imported by the cache and by the
// backing-memory responder so both agree on the block layout.
package cache_pkg;

    localparam int CACHE_DATA_BITS  = 32;
    localparam int CACHE_BLOCK_BITS = 2;
    localparam int CACHE_BLOCK_SIZE = 1 << CACHE_BLOCK_BITS;

    // One cache line, word 0 at index 0.
    typedef logic [CACHE_DATA_BITS-1:0] cache_block_t [CACHE_BLOCK_SIZE];

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP,
        HOLD
    } resp_state_t;

    // Word address -> block index (drops the in-block offset bits).
    // Callers size-cast the result to their index width.
    function automatic logic [31:0] block_index(input logic [31:0] addr,
                                                input int          block_bits);
        return addr >> block_bits;
    endfunction

endpackage

// File: rtl/cache_ram_array.sv
// Block-wide backing store: one full block read or written per access.
// Synchronous write, synchronous (registered) read. Contents start at
// INIT_VALUE and are never reset.
//   clk          clock
//   we/waddr     write enable / block index
//   wdata        block to write
//   re/raddr     read enable / block index
//   rdata        registered read block, holds between reads
module cache_ram_array
    import cache_pkg::*;
#(
    parameter int                         IDX_W      = 8,
    parameter logic [CACHE_DATA_BITS-1:0] INIT_VALUE = '1
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [IDX_W-1:0]           waddr,
    input  logic [CACHE_DATA_BITS-1:0] wdata [CACHE_BLOCK_SIZE],
    input  logic                       re,
    input  logic [IDX_W-1:0]           raddr,
    output logic [CACHE_DATA_BITS-1:0] rdata [CACHE_BLOCK_SIZE]
);

    cache_block_t mem [2**IDX_W] = '{default: '{default: INIT_VALUE}};

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/cache_ram_responder.sv
// Backing-memory responder for the cache miss / write-back port.
// Accepts a line fill, a dirty-victim write-back, or both at once (write
// runs first), waits the modelled latency and answers with a one-cycle
// ram_valid pulse. A dead HOLD cycle follows every response so the cache's
// registered, still-asserted request is not taken as a new one.
//   clk, reset_n                 clock, async active-low reset
//   prop_address / prop_read_en  fill request (level)
//   prop_write_address / _en     write-back request (level)
//   prop_write_data              victim block
//   ram_valid / ram_data         completion pulse / fill block
//   busy                         not idle
// Optional: define CACHE_RAM_STATS_EN to add saturating read_count and
// write_count outputs.
module cache_ram_responder
    import cache_pkg::*;
#(
    parameter int                   RAM_ADDRESS_BITS = 10,
    parameter int                   DATA_BITS        = 32,
    parameter int                   BLOCK_BITS       = 2,
    parameter int                   READ_LATENCY     = 4,
    parameter int                   WRITE_LATENCY    = 3,
    parameter logic [DATA_BITS-1:0] INIT_VALUE       = '1,
    localparam int                  BLOCK_SIZE       = 2**BLOCK_BITS
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [RAM_ADDRESS_BITS-1:0] prop_address,
    input  logic                        prop_read_en,
    input  logic [RAM_ADDRESS_BITS-1:0] prop_write_address,
    input  logic                        prop_write_en,
    input  logic [DATA_BITS-1:0]        prop_write_data [BLOCK_SIZE],
    output logic                        ram_valid,
    output logic [DATA_BITS-1:0]        ram_data [BLOCK_SIZE],
    output logic                        busy
`ifdef CACHE_RAM_STATS_EN
    ,
    output logic [15:0]                 read_count,
    output logic [15:0]                 write_count
`endif
);

    localparam int IDX_W   = RAM_ADDRESS_BITS - BLOCK_BITS;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    if (READ_LATENCY < 1) begin : g_rl_chk
        $error("READ_LATENCY must be >= 1");
    end
    if (WRITE_LATENCY < 1) begin : g_wl_chk
        $error("WRITE_LATENCY must be >= 1");
    end
    if (DATA_BITS != CACHE_DATA_BITS || BLOCK_SIZE != CACHE_BLOCK_SIZE) begin : g_blk_chk
        $error("block geometry must match cache_pkg");
    end

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    resp_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept_wr, accept_rd;
    logic             mem_we, mem_re, data_clr;
    logic             rd_pend_q;     // fill latched together with the write-back
    logic             data_zero_q;   // forces ram_data to zero (reset, write-only)
    logic [IDX_W-1:0] wr_idx_q, rd_idx_q;
    cache_block_t     wr_data_q;
    cache_block_t     arr_rdata;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept_wr = 1'b0;
        accept_rd = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        data_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (prop_write_en) begin
                    accept_wr = 1'b1;
                    accept_rd = prop_read_en;
                    state_nxt = WRITE;
                    cnt_nxt   = WR_LOAD;
                end else if (prop_read_en) begin
                    accept_rd = 1'b1;
                    state_nxt = READ;
                    cnt_nxt   = RD_LOAD;
                end
            end
            WRITE: begin
                if (cnt == '0) begin
                    mem_we = 1'b1;
                    if (rd_pend_q) begin
                        state_nxt = READ;
                        cnt_nxt   = RD_LOAD;
                    end else begin
                        state_nxt = RESP;
                        data_clr  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            READ: begin
                if (cnt == '0) begin
                    mem_re    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP:    state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rd_pend_q   <= 1'b0;
            data_zero_q <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE) rd_pend_q <= accept_rd;
            if (data_clr)      data_zero_q <= 1'b1;
            else if (mem_re)   data_zero_q <= 1'b0;
        end
    end

    // Request payload latches; contents only matter while an op is in flight.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            wr_idx_q  <= IDX_W'(block_index(32'(prop_write_address), BLOCK_BITS));
            wr_data_q <= prop_write_data;
        end
        if (accept_rd) rd_idx_q <= IDX_W'(block_index(32'(prop_address), BLOCK_BITS));
    end

    cache_ram_array #(
        .IDX_W      (IDX_W),
        .INIT_VALUE (INIT_VALUE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_idx_q),
        .wdata (wr_data_q),
        .re    (mem_re),
        .raddr (rd_idx_q),
        .rdata (arr_rdata)
    );

    assign ram_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_comb begin
        for (int i = 0; i < BLOCK_SIZE; i++)
            ram_data[i] = data_zero_q ? '0 : arr_rdata[i];
    end

`ifdef CACHE_RAM_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_count  <= '0;
            write_count <= '0;
        end else begin
            if (mem_re && read_count != 16'hFFFF)  read_count  <= read_count + 16'd1;
            if (mem_we && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
        end
    end
`endif

endmodule
